// File: rtl/pool7x7_collector.sv
// pool7x7_collector: steps the max-pool window select through 0..N_OUT-1,
// packs each pooled byte into a 7x7 map and offers the map downstream
// over a valid/ready handshake.
module pool7x7_collector #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_OUT  = 49,
  parameter int unsigned IDX_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    in_ready,
  output logic [IDX_W-1:0]        pool_idx,
  input  logic [DATA_W-1:0]       pool_val,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_OUT*DATA_W-1:0] out_map
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [N_OUT*DATA_W-1:0] map_q, map_d;

  // State, window index and packed map registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      map_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      map_q   <= map_d;
    end
  end

  // Next-state logic: scan windows in order, capture each result, then hold the map.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    map_d   = map_q;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (start) begin
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        // Slot decode by constant compare keeps every part-select static.
        for (int unsigned k = 0; k < N_OUT; k++) begin
          if (idx_q == IDX_W'(k)) begin
            map_d[k*DATA_W +: DATA_W] = pool_val;
          end
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_HOLD;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_HOLD: begin
        idx_d = '0;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_SCAN);
  assign out_valid = (state_q == S_HOLD);
  assign pool_idx  = idx_q;
  assign out_map   = map_q;

endmodule

// File: tb/tb_pool7x7_collector.sv
// Directed bench for pool7x7_collector: ramp capture, handshake, ignored
// start, mid-scan abort and an integrated 14x14 max-pool frame.
module tb_pool7x7_collector;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned N_OUT  = 49;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned MAP_W  = N_OUT * DATA_W;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             in_ready;
  logic [IDX_W-1:0] pool_idx;
  logic [7:0]       pool_val;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [MAP_W-1:0] out_map;

  int total = 0;
  int bad   = 0;

  // 0: ramp pool_idx+ofs, 1: constant FF, 2: max-pool over pix[]
  int         mode = 0;
  logic [7:0] ofs  = 8'h10;
  logic [7:0] pix [0:195];

  logic [MAP_W-1:0] exp_map;
  logic [MAP_W-1:0] held_map;
  int               busy_cnt;

  pool7x7_collector #(
    .DATA_W(DATA_W),
    .N_OUT (N_OUT),
    .IDX_W (IDX_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_ready (in_ready),
    .pool_idx (pool_idx),
    .pool_val (pool_val),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_map  (out_map)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 2x2 max-pool over a 14x14 frame
  function automatic logic [7:0] maxpool(input logic [IDX_W-1:0] idx);
    int r0, c0;
    logic [7:0] m;
    r0 = 2 * (int'(idx) / 7);
    c0 = 2 * (int'(idx) % 7);
    m  = pix[r0*14 + c0];
    if (pix[r0*14 + c0 + 1] > m)       m = pix[r0*14 + c0 + 1];
    if (pix[(r0+1)*14 + c0] > m)       m = pix[(r0+1)*14 + c0];
    if (pix[(r0+1)*14 + c0 + 1] > m)   m = pix[(r0+1)*14 + c0 + 1];
    return m;
  endfunction

  // Upstream pool stage stand-in
  always_comb begin
    pool_val = 8'h00;
    case (mode)
      0:       pool_val = 8'(pool_idx) + ofs;
      1:       pool_val = 8'hFF;
      default: pool_val = maxpool(pool_idx);
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [MAP_W-1:0] obs, input logic [MAP_W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    for (int r = 0; r < 14; r++)
      for (int c = 0; c < 14; c++)
        pix[r*14 + c] = 8'(r*14 + c);

    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_idx",   MAP_W'(pool_idx),  '0);
    check("rst_map",   out_map,           '0);
    check("rst_valid", MAP_W'(out_valid), '0);
    check("rst_busy",  MAP_W'(busy),      '0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", MAP_W'(in_ready), MAP_W'(1));

    // Ramp frame, out_ready low
    mode = 0; ofs = 8'h10;
    for (int k = 0; k < 49; k++) exp_map[8*k +: 8] = 8'(k + 16);
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = 0;
    check("scan_busy",     MAP_W'(busy),     MAP_W'(1));
    check("scan_in_ready", MAP_W'(in_ready), '0);
    check("scan_idx0",     MAP_W'(pool_idx), '0);
    for (int i = 1; i <= 48; i++) begin
      if (busy) busy_cnt++;
      tick();
      check("ramp_idx",   MAP_W'(pool_idx),  MAP_W'(i));
      check("ramp_novld", MAP_W'(out_valid), '0);
    end
    if (busy) busy_cnt++;
    tick();
    check("busy_cycles", MAP_W'(busy_cnt),  MAP_W'(49));
    check("ramp_valid",  MAP_W'(out_valid), MAP_W'(1));
    check("hold_busy",   MAP_W'(busy),      '0);
    check("hold_idx",    MAP_W'(pool_idx),  '0);
    check("ramp_map",    out_map,           exp_map);
    held_map = out_map;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", MAP_W'(out_valid), MAP_W'(1));
      check("hold_map",   out_map,           held_map);
    end

    // Handshake with simultaneous start: only leaves HOLD
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs_idle_vld",  MAP_W'(out_valid), '0);
    check("hs_in_ready",  MAP_W'(in_ready),  MAP_W'(1));
    check("hs_no_scan",   MAP_W'(busy),      '0);
    tick();
    start = 1'b0;
    check("hs_new_scan",  MAP_W'(busy),      MAP_W'(1));

    // Start ignored during scan; new offset proves all slots overwritten
    ofs = 8'h40;
    for (int k = 0; k < 49; k++) exp_map[8*k +: 8] = 8'(k + 64);
    for (int i = 0; i < 20; i++) tick();
    check("ign_idx20", MAP_W'(pool_idx), MAP_W'(20));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_idx21", MAP_W'(pool_idx), MAP_W'(21));
    tick();
    check("ign_idx22", MAP_W'(pool_idx), MAP_W'(22));
    for (int i = 0; i < 26; i++) tick();
    check("ign_novld", MAP_W'(out_valid), '0);
    tick();
    check("ign_valid", MAP_W'(out_valid), MAP_W'(1));
    check("ign_map",   out_map,           exp_map);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ign_idle", MAP_W'(in_ready), MAP_W'(1));

    // Abort at idx 30 with an asynchronous mid-cycle reset
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    check("abort_idx30", MAP_W'(pool_idx), MAP_W'(30));
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_idx",   MAP_W'(pool_idx),  '0);
    check("abort_map",   out_map,           '0);
    check("abort_busy",  MAP_W'(busy),      '0);
    check("abort_valid", MAP_W'(out_valid), '0);
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_in_ready", MAP_W'(in_ready), MAP_W'(1));
    check("abort_map_zero", out_map,          '0);

    // All-FF frame, out_ready held high throughout
    mode = 1;
    exp_map = '1;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 48; i++) tick();
    check("ff_still_busy", MAP_W'(busy), MAP_W'(1));
    tick();
    check("ff_valid", MAP_W'(out_valid), MAP_W'(1));
    check("ff_map",   out_map,           exp_map);
    tick();
    check("ff_e50_idle", MAP_W'(in_ready), MAP_W'(1));

    // Integrated frame accepted at E51 of the previous one
    mode = 2;
    for (int k = 0; k < 49; k++) exp_map[8*k +: 8] = 8'((2*(k/7)+1)*14 + 2*(k%7)+1);
    start = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    check("int_e51_busy", MAP_W'(busy), MAP_W'(1));
    for (int i = 0; i < 49; i++) tick();
    check("int_valid", MAP_W'(out_valid), MAP_W'(1));
    check("int_map",   out_map,           exp_map);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("int_idle", MAP_W'(in_ready), MAP_W'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
